// File: rtl/message_slicer_stream.sv
// message_slicer_stream
//   Buffers wide words in a FIFO and emits each one as a stream of WIDTH-bit
//   slices, one slice per accepted output beat. Each word carries its own
//   slice count, so short words emit fewer slices. The output stage is fully
//   registered and reads the head of the FIFO directly.
//
// Ports
//   clk          sole clock, rising edge
//   rst_n        asynchronous active-low reset
//   in_data      input word, WIDTH*N_SLICES bits
//   in_nslices   number of valid slices in in_data (1..N_SLICES)
//   in_valid     in_data/in_nslices valid
//   in_ready     word can be accepted (count < BUFFER_LENGTH)
//   out_data     current slice
//   out_valid    out_data valid
//   out_ready    downstream accepts slice
//   out_last     current slice is the last of its word
//   count        words held, not yet fully emitted
//   error        sticky bad-length flag
//   clear_error  synchronous clear of error
module message_slicer_stream #(
  parameter int N_SLICES          = 4,
  parameter int LOG_N_SLICES      = 2,
  parameter int WIDTH             = 32,
  parameter int BUFFER_LENGTH     = 16,
  parameter int LOG_BUFFER_LENGTH = 4,
  parameter bit MSB_FIRST         = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [WIDTH*N_SLICES-1:0]     in_data,
  input  logic [LOG_N_SLICES:0]         in_nslices,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [WIDTH-1:0]              out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_last,
  output logic [LOG_BUFFER_LENGTH:0]    count,
  output logic                          error,
  input  logic                          clear_error
);

  localparam logic [LOG_N_SLICES:0]      NS_MAX  = (LOG_N_SLICES+1)'(N_SLICES);
  localparam logic [LOG_N_SLICES:0]      NS_ONE  = (LOG_N_SLICES+1)'(1);
  localparam logic [LOG_BUFFER_LENGTH:0] CNT_MAX = (LOG_BUFFER_LENGTH+1)'(BUFFER_LENGTH);
  localparam logic [LOG_BUFFER_LENGTH:0] CNT_ONE = (LOG_BUFFER_LENGTH+1)'(1);

  logic [WIDTH*N_SLICES-1:0]  word_mem [BUFFER_LENGTH];
  logic [LOG_N_SLICES:0]      ns_mem   [BUFFER_LENGTH];
  logic [LOG_BUFFER_LENGTH-1:0] wr_ptr;
  logic [LOG_BUFFER_LENGTH-1:0] rd_ptr;
  logic [LOG_N_SLICES-1:0]      slice_idx;

  logic                         len_ok;
  logic                         xfer;
  logic                         wr_en;
  logic                         accept;
  logic                         retire;
  logic                         load;
  logic [LOG_BUFFER_LENGTH-1:0] load_ptr;
  logic [LOG_N_SLICES-1:0]      load_idx;
  logic [WIDTH*N_SLICES-1:0]    load_word;
  logic [LOG_N_SLICES:0]        load_ns;
  logic [WIDTH-1:0]             load_data;
  logic                         load_last;

  // Extract slice k of a word, honouring the slice ordering parameter.
  function automatic logic [WIDTH-1:0] get_slice(input logic [WIDTH*N_SLICES-1:0] word,
                                                 input logic [LOG_N_SLICES-1:0] k);
    logic [WIDTH-1:0] res;
    int               sel;
    res = '0;
    sel = MSB_FIRST ? (N_SLICES - 1 - int'(k)) : int'(k);
    for (int i = 0; i < N_SLICES; i++) begin
      if (i == sel) begin
        res = word[i*WIDTH +: WIDTH];
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  assign in_ready = (count < CNT_MAX);
  assign len_ok   = (in_nslices != '0) && (in_nslices <= NS_MAX);
  assign xfer     = in_valid & in_ready;
  assign wr_en    = xfer & len_ok;
  assign accept   = out_valid & out_ready;
  assign retire   = accept & out_last;

  // Decide whether the output register reloads this edge and from where.
  // The presented word always stays at the FIFO head until its last slice
  // is accepted, so an idle output with count>0 means the head is unstarted.
  always_comb begin
    load     = 1'b0;
    load_ptr = rd_ptr;
    load_idx = '0;
    if (!out_valid) begin
      if (count != '0) begin
        load = 1'b1;
      end else begin
        load = 1'b0;
      end
    end else if (accept) begin
      if (out_last) begin
        // Only a word already stored behind the head can follow back-to-back.
        load     = (count > CNT_ONE);
        load_ptr = rd_ptr + 1'b1;
      end else begin
        load     = 1'b1;
        load_idx = slice_idx + 1'b1;
      end
    end else begin
      load = 1'b0;
    end
  end

  assign load_word = word_mem[load_ptr];
  assign load_ns   = ns_mem[load_ptr];
  assign load_data = get_slice(load_word, load_idx);
  assign load_last = ({1'b0, load_idx} == (load_ns - NS_ONE));

  // FIFO storage; contents need no reset since pointers and count gate reads.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      word_mem[wr_ptr] <= in_data;
      ns_mem[wr_ptr]   <= in_nslices;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en)  wr_ptr <= wr_ptr + 1'b1;
      if (retire) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, retire})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Registered output slice stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      slice_idx <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= load_data;
      out_last  <= load_last;
      slice_idx <= load_idx;
    end else if (accept) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      slice_idx <= '0;
    end
  end

  // Sticky length error; a new bad transfer wins over a same-edge clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      error <= 1'b0;
    end else if (xfer && !len_ok) begin
      error <= 1'b1;
    end else if (clear_error) begin
      error <= 1'b0;
    end
  end

endmodule

// File: tb/tb_message_slicer_stream.sv
module tb_message_slicer_stream;

  logic        clk;
  logic        rst_n;
  logic [31:0] in_data;
  logic [2:0]  in_nslices;
  logic        in_valid_a;
  logic        in_valid_b;
  logic        out_ready;
  logic        clear_error;

  logic        in_ready_a, out_valid_a, out_last_a, error_a;
  logic [7:0]  out_data_a;
  logic [2:0]  count_a;
  logic        in_ready_b, out_valid_b, out_last_b, error_b;
  logic [7:0]  out_data_b;
  logic [2:0]  count_b;

  int checks = 0;
  int errors = 0;

  message_slicer_stream #(
    .N_SLICES(4), .LOG_N_SLICES(2), .WIDTH(8),
    .BUFFER_LENGTH(4), .LOG_BUFFER_LENGTH(2), .MSB_FIRST(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_nslices(in_nslices),
    .in_valid(in_valid_a), .in_ready(in_ready_a), .out_data(out_data_a),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_last(out_last_a),
    .count(count_a), .error(error_a), .clear_error(clear_error)
  );

  message_slicer_stream #(
    .N_SLICES(4), .LOG_N_SLICES(2), .WIDTH(8),
    .BUFFER_LENGTH(4), .LOG_BUFFER_LENGTH(2), .MSB_FIRST(1'b0)
  ) dut_lsb (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_nslices(in_nslices),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .out_data(out_data_b),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_last(out_last_b),
    .count(count_b), .error(error_b), .clear_error(clear_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [7:0] exp_seq [7];
  logic       exp_lst [7];
  int         idx;

  initial begin
    rst_n = 1'b0; in_data = 32'h0; in_nslices = 3'd0;
    in_valid_a = 1'b0; in_valid_b = 1'b0; out_ready = 1'b0; clear_error = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid_a), 32'd0);
    chk("rst_out_data",  32'(out_data_a),  32'd0);
    chk("rst_count",     32'(count_a),     32'd0);
    chk("rst_in_ready",  32'(in_ready_a),  32'd1);
    chk("rst_error",     32'(error_a),     32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // MSB-first, 4 slices, back-to-back with out_ready high
    in_data = 32'h11223344; in_nslices = 3'd4; in_valid_a = 1'b1; out_ready = 1'b1;
    tick();
    in_valid_a = 1'b0;
    chk("msb_count_after_accept", 32'(count_a), 32'd1);
    chk("msb_not_yet_valid", 32'(out_valid_a), 32'd0);
    tick();
    chk("msb_s0", {23'd0, out_valid_a, out_data_a}, {23'd0, 1'b1, 8'h11});
    chk("msb_s0_last", 32'(out_last_a), 32'd0);
    tick();
    chk("msb_s1", {23'd0, out_valid_a, out_data_a}, {23'd0, 1'b1, 8'h22});
    chk("msb_s1_last", 32'(out_last_a), 32'd0);
    tick();
    chk("msb_s2", {23'd0, out_valid_a, out_data_a}, {23'd0, 1'b1, 8'h33});
    chk("msb_s2_last", 32'(out_last_a), 32'd0);
    tick();
    chk("msb_s3", {23'd0, out_valid_a, out_data_a}, {23'd0, 1'b1, 8'h44});
    chk("msb_s3_last", 32'(out_last_a), 32'd1);
    tick();
    chk("msb_done_valid", 32'(out_valid_a), 32'd0);
    chk("msb_done_count", 32'(count_a), 32'd0);

    // LSB-first, 2 slices
    in_data = 32'h11223344; in_nslices = 3'd2; in_valid_b = 1'b1;
    tick();
    in_valid_b = 1'b0;
    tick();
    chk("lsb_s0", {23'd0, out_valid_b, out_data_b}, {23'd0, 1'b1, 8'h44});
    chk("lsb_s0_last", 32'(out_last_b), 32'd0);
    tick();
    chk("lsb_s1", {23'd0, out_valid_b, out_data_b}, {23'd0, 1'b1, 8'h33});
    chk("lsb_s1_last", 32'(out_last_b), 32'd1);
    tick();
    chk("lsb_done_valid", 32'(out_valid_b), 32'd0);

    // Fill FIFO with out_ready low: fifth word must be refused
    out_ready = 1'b0; in_nslices = 3'd4; in_valid_a = 1'b1;
    in_data = 32'h01020304; tick();
    in_data = 32'h05060708; tick();
    in_data = 32'h090a0b0c; tick();
    in_data = 32'h0d0e0f10; tick();
    chk("full_in_ready", 32'(in_ready_a), 32'd0);
    in_data = 32'h11121314; tick();
    in_valid_a = 1'b0;
    chk("full_count", 32'(count_a), 32'd4);
    chk("full_in_ready_hold", 32'(in_ready_a), 32'd0);
    chk("full_head_stalled", {23'd0, out_valid_a, out_data_a}, {23'd0, 1'b1, 8'h01});
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("drain_data", {23'd0, out_valid_a, out_data_a}, {23'd0, 1'b1, 8'(i + 1)});
      chk("drain_last", 32'(out_last_a), 32'((i % 4) == 3));
      tick();
    end
    chk("drain_done_valid", 32'(out_valid_a), 32'd0);
    chk("drain_done_count", 32'(count_a), 32'd0);
    chk("drain_in_ready", 32'(in_ready_a), 32'd1);

    // Bad lengths are consumed and flag error
    in_valid_a = 1'b1; in_nslices = 3'd0; in_data = 32'hdeadbeef;
    tick();
    chk("bad0_error", 32'(error_a), 32'd1);
    chk("bad0_count", 32'(count_a), 32'd0);
    in_nslices = 3'd5;
    tick();
    in_valid_a = 1'b0;
    tick();
    chk("bad5_not_emitted", 32'(out_valid_a), 32'd0);
    chk("bad5_count", 32'(count_a), 32'd0);
    chk("bad5_error", 32'(error_a), 32'd1);
    clear_error = 1'b1;
    tick();
    clear_error = 1'b0;
    chk("clear_error", 32'(error_a), 32'd0);
    in_valid_a = 1'b1; in_nslices = 3'd0; clear_error = 1'b1;
    tick();
    in_valid_a = 1'b0; clear_error = 1'b0;
    chk("bad_wins_over_clear", 32'(error_a), 32'd1);
    clear_error = 1'b1;
    tick();
    clear_error = 1'b0;
    chk("clear_error_again", 32'(error_a), 32'd0);

    // Stall toggling across two words
    exp_seq[0] = 8'ha1; exp_seq[1] = 8'ha2; exp_seq[2] = 8'ha3; exp_seq[3] = 8'ha4;
    exp_seq[4] = 8'hb1; exp_seq[5] = 8'hb2; exp_seq[6] = 8'hb3;
    exp_lst[0] = 1'b0; exp_lst[1] = 1'b0; exp_lst[2] = 1'b0; exp_lst[3] = 1'b1;
    exp_lst[4] = 1'b0; exp_lst[5] = 1'b0; exp_lst[6] = 1'b1;
    out_ready = 1'b0; in_valid_a = 1'b1;
    in_data = 32'ha1a2a3a4; in_nslices = 3'd4; tick();
    in_data = 32'hb1b2b3b4; in_nslices = 3'd3; tick();
    in_valid_a = 1'b0;
    idx = 0;
    for (int c = 0; c < 20; c++) begin
      if (idx < 7) begin
        out_ready = ((c % 2) == 0);
        chk("stall_data", {23'd0, out_valid_a, out_data_a}, {23'd0, 1'b1, exp_seq[idx]});
        chk("stall_last", 32'(out_last_a), 32'(exp_lst[idx]));
        tick();
        if (out_ready) idx++;
      end
    end
    out_ready = 1'b0;
    chk("stall_all_emitted", 32'(idx), 32'd7);
    chk("stall_done_valid", 32'(out_valid_a), 32'd0);
    chk("stall_done_count", 32'(count_a), 32'd0);

    // Reset mid-word, then restart from slice 0 of a new word
    out_ready = 1'b1; in_valid_a = 1'b1;
    in_data = 32'h11223344; in_nslices = 3'd4; tick();
    in_valid_a = 1'b0;
    tick();
    chk("pre_rst_s0", {23'd0, out_valid_a, out_data_a}, {23'd0, 1'b1, 8'h11});
    tick();
    chk("pre_rst_s1", {23'd0, out_valid_a, out_data_a}, {23'd0, 1'b1, 8'h22});
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(out_valid_a), 32'd0);
    chk("midrst_count", 32'(count_a), 32'd0);
    chk("midrst_in_ready", 32'(in_ready_a), 32'd1);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_idle", 32'(out_valid_a), 32'd0);
    in_valid_a = 1'b1; in_data = 32'h55667788; in_nslices = 3'd2; tick();
    in_valid_a = 1'b0;
    tick();
    chk("post_rst_s0", {23'd0, out_valid_a, out_data_a}, {23'd0, 1'b1, 8'h55});
    chk("post_rst_s0_last", 32'(out_last_a), 32'd0);
    tick();
    chk("post_rst_s1", {23'd0, out_valid_a, out_data_a}, {23'd0, 1'b1, 8'h66});
    chk("post_rst_s1_last", 32'(out_last_a), 32'd1);
    tick();
    chk("post_rst_done", 32'(out_valid_a), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/message_slicer_stream.md
MESSAGE_SLICER_STREAM -- requirements
Module: message_slicer_stream

Interface
REQ-001 SHALL have parameter N_SLICES, default 4, max slices per input word.
REQ-002 SHALL have parameter LOG_N_SLICES, default 2, width of the slice index.
REQ-003 SHALL have parameter WIDTH, default 32, bits per output slice.
REQ-004 SHALL have parameter BUFFER_LENGTH, default 16, word FIFO depth (power of 2).
REQ-005 SHALL have parameter LOG_BUFFER_LENGTH, default 4, FIFO pointer width.
REQ-006 SHALL have parameter MSB_FIRST, default 1: 1 emits slice 0 from the top bits, 0 from the bottom bits.
REQ-007 SHALL have port clk  input  1  sole clock, rising edge.
REQ-008 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-009 SHALL have port in_data  input  WIDTH*N_SLICES  input word.
REQ-010 SHALL have port in_nslices  input  LOG_N_SLICES+1  number of valid slices in in_data (1..N_SLICES).
REQ-011 SHALL have port in_valid  input  1  in_data/in_nslices valid.
REQ-012 SHALL have port in_ready  output  1  word can be accepted.
REQ-013 SHALL have port out_data  output  WIDTH  current slice.
REQ-014 SHALL have port out_valid  output  1  out_data valid.
REQ-015 SHALL have port out_ready  input  1  downstream accepts slice.
REQ-016 SHALL have port out_last  output  1  current slice is last of its word.
REQ-017 SHALL have port count  output  LOG_BUFFER_LENGTH+1  words held, not yet fully emitted.
REQ-018 SHALL have port error  output  1  sticky bad-length flag.
REQ-019 SHALL have port clear_error  input  1  synchronous clear of error.

Function
REQ-020 Input transfer SHALL occur on a rising edge where in_valid=1 and in_ready=1.
REQ-021 in_ready SHALL be 1 iff count < BUFFER_LENGTH; no same-cycle pass-through when full, even if a word retires that cycle.
REQ-022 A transfer with in_nslices=0 or in_nslices>N_SLICES SHALL be consumed, not stored, and SHALL set error.
REQ-023 Valid words SHALL be stored with their in_nslices in FIFO order; write pointer wraps BUFFER_LENGTH-1 -> 0.
REQ-024 Slice k (0-based) SHALL be in_data[(N_SLICES-k)*WIDTH-1 -: WIDTH] if MSB_FIRST=1, else in_data[(k+1)*WIDTH-1 -: WIDTH].
REQ-025 Output SHALL be registered: out_valid, out_data, out_last change only on rising edges.
REQ-026 With output idle and FIFO empty, a word accepted at edge T SHALL present slice 0 with out_valid=1 after edge T+1.
REQ-027 out_data/out_last SHALL hold stable while out_valid=1 and out_ready=0.
REQ-028 Slice acceptance (out_valid & out_ready) SHALL load the next slice on the same edge, giving one slice per cycle with out_ready held high, including across word boundaries.
REQ-029 out_last SHALL be 1 on slice in_nslices-1 of each word; acceptance of that slice retires the word (count decrements, read pointer wraps).
REQ-030 count SHALL update on each edge by +1 per stored write and -1 per retirement; both together leave it unchanged.
REQ-031 error SHALL stay 1 until clear_error=1 at an edge; a bad-length transfer on the same edge as clear_error SHALL leave error=1.
REQ-032 out_valid SHALL fall after the edge accepting the final slice when no further word is buffered.

Reset
REQ-033 rst_n=0 SHALL immediately force out_valid=0, out_last=0, out_data=0, count=0, error=0, pointers and slice index to 0; in_ready=1 once rst_n=0 (count=0).
REQ-034 Reset mid-word SHALL discard all buffered words and partial slices; after release, output resumes only with newly accepted words.

Verification
REQ-035 WIDTH=8, N_SLICES=4, MSB_FIRST=1: in_data=0x11223344, nslices=4, out_ready=1 -> out_data 0x11,0x22,0x33,0x44 on consecutive cycles, out_last only with 0x44.
REQ-036 Same, MSB_FIRST=0, nslices=2 -> out_data 0x44,0x33, out_last with 0x33, then out_valid=0.
REQ-037 BUFFER_LENGTH=4, out_ready=0, five in_valid words -> four accepted, count=4, in_ready=0; then out_ready=1 -> 16 slices in order, count reaches 0.
REQ-038 in_nslices=0 then 5 -> neither emitted, error=1 after first; clear_error pulse -> error=0.
REQ-039 out_ready toggled 1,0,1,0 over two words -> no slice lost or duplicated, data held during stalls.
REQ-040 rst_n low while second slice pending -> out_valid=0, count=0 immediately; new word after release emits from slice 0.
